// File: rtl/idct_8x8_decoder.sv
// idct_8x8_decoder: serial 8x8 inverse DCT, X = D^T * C * D, one MAC per cycle.
// Revision: 1.0 - initial release
`default_nettype none

module idct_8x8_decoder #(
  parameter int COEF_W = 16,
  parameter int ACC_W  = 32,
  parameter int MID_W  = 20,
  parameter int OFFSET = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [COEF_W-1:0] in_coef,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               out_pixel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_PASS1 = 2'd1;
  localparam logic [1:0] S_PASS2 = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // D[row][col] = round(128 * orthonormal DCT-II basis), row-major
  localparam logic signed [7:0] DMAT [64] = '{
    8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,
    8'sd63,  8'sd53,  8'sd36,  8'sd12, -8'sd12, -8'sd36, -8'sd53, -8'sd63,
    8'sd59,  8'sd24, -8'sd24, -8'sd59, -8'sd59, -8'sd24,  8'sd24,  8'sd59,
    8'sd53, -8'sd12, -8'sd63, -8'sd36,  8'sd36,  8'sd63,  8'sd12, -8'sd53,
    8'sd45, -8'sd45, -8'sd45,  8'sd45,  8'sd45, -8'sd45, -8'sd45,  8'sd45,
    8'sd36, -8'sd63,  8'sd12,  8'sd53, -8'sd53, -8'sd12,  8'sd63, -8'sd36,
    8'sd24, -8'sd59,  8'sd59, -8'sd24, -8'sd24,  8'sd59, -8'sd59,  8'sd24,
    8'sd12, -8'sd36,  8'sd53, -8'sd63,  8'sd63, -8'sd53,  8'sd36, -8'sd12
  };

  localparam logic signed [ACC_W-1:0] MID_MAX = ACC_W'((longint'(1) <<< (MID_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] MID_MIN = ACC_W'(-(longint'(1) <<< (MID_W-1)));
  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(64);
  localparam logic signed [ACC_W-1:0] LEVEL   = ACC_W'(OFFSET);
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(255);

  logic [1:0]              state;
  logic [8:0]              cnt;
  logic signed [ACC_W-1:0] acc;

  logic signed [COEF_W-1:0] cbuf [64];
  logic signed [MID_W-1:0]  tbuf [64];
  logic [7:0]               pbuf [64];

  logic [2:0]              row_i;
  logic [2:0]              col_k;
  logic [2:0]              tap_j;
  logic signed [MID_W-1:0] op_a;
  logic signed [7:0]       op_d;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] biased;
  logic signed [MID_W-1:0] t_sat;
  logic [7:0]              pix;

  // cnt walks (i,k,j) with j fastest during both passes
  assign row_i = cnt[8:6];
  assign col_k = cnt[5:3];
  assign tap_j = cnt[2:0];

  always_comb begin
    op_a = '0;
    op_d = '0;
    if (state == S_PASS1) begin
      op_a = MID_W'(cbuf[{tap_j, col_k}]);
      op_d = DMAT[{tap_j, row_i}];
    end else begin
      op_a = tbuf[{row_i, tap_j}];
      op_d = DMAT[{tap_j, col_k}];
    end
  end

  assign prod    = ACC_W'(op_a) * ACC_W'(op_d);
  assign acc_sum = ((tap_j == 3'd0) ? '0 : acc) + prod;
  assign rounded = (acc_sum + HALF) >>> 7;
  assign biased  = rounded + LEVEL;

  always_comb begin
    t_sat = rounded[MID_W-1:0];
    if (rounded > MID_MAX)
      t_sat = MID_MAX[MID_W-1:0];
    else if (rounded < MID_MIN)
      t_sat = MID_MIN[MID_W-1:0];
  end

  always_comb begin
    pix = biased[7:0];
    if (biased < 0)
      pix = 8'd0;
    else if (biased > PIX_MAX)
      pix = 8'd255;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_LOAD;
      cnt       <= '0;
      acc       <= '0;
      out_pixel <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            if (cnt[5:0] == 6'd63) begin
              state <= S_PASS1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 9'd1;
            end
          end
        end
        S_PASS1: begin
          acc <= acc_sum;
          cnt <= cnt + 9'd1;
          if (cnt == 9'd511)
            state <= S_PASS2;
        end
        S_PASS2: begin
          acc <= acc_sum;
          cnt <= cnt + 9'd1;
          if (cnt == 9'd511) begin
            state     <= S_DRAIN;
            out_pixel <= pbuf[0];
          end
        end
        default: begin
          if (out_ready) begin
            if (cnt[5:0] == 6'd63) begin
              state <= S_LOAD;
              cnt   <= '0;
            end else begin
              cnt       <= cnt + 9'd1;
              out_pixel <= pbuf[cnt[5:0] + 6'd1];
            end
          end
        end
      endcase
    end
  end

  // Storage arrays carry no reset; their contents are rewritten every block
  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid)
      cbuf[cnt[5:0]] <= in_coef;
    if (state == S_PASS1 && tap_j == 3'd7)
      tbuf[{row_i, col_k}] <= t_sat;
    if (state == S_PASS2 && tap_j == 3'd7)
      pbuf[{row_i, col_k}] <= pix;
  end

  assign in_ready  = (state == S_LOAD);
  assign busy      = (state != S_LOAD);
  assign out_valid = (state == S_DRAIN);
  assign out_last  = (state == S_DRAIN) && (cnt[5:0] == 6'd63);

endmodule

`default_nettype wire

// File: tb/tb_idct_8x8_decoder.sv
// tb_idct_8x8_decoder: drives two decoders (OFFSET 0 and 128) in lockstep against a scoreboard.
`default_nettype none

module tb_idct_8x8_decoder;

  localparam int COEF_W = 16;

  logic                     clk = 1'b0;
  logic                     reset;
  logic signed [COEF_W-1:0] in_coef;
  logic                     in_valid;
  logic                     out_ready;

  logic       in_ready0, out_valid0, out_last0, busy0;
  logic       in_ready1, out_valid1, out_last1, busy1;
  logic [7:0] out_pixel0, out_pixel1;

  int tests = 0;
  int fails = 0;
  int cur [64];
  int dm  [64];
  int q0 [$];
  int q1 [$];

  always #5 clk = ~clk;

  idct_8x8_decoder #(.COEF_W(COEF_W), .ACC_W(32), .MID_W(20), .OFFSET(0)) dut0 (
    .clk(clk), .reset(reset), .in_coef(in_coef), .in_valid(in_valid), .in_ready(in_ready0),
    .out_pixel(out_pixel0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_last(out_last0), .busy(busy0)
  );

  idct_8x8_decoder #(.COEF_W(COEF_W), .ACC_W(32), .MID_W(20), .OFFSET(128)) dut1 (
    .clk(clk), .reset(reset), .in_coef(in_coef), .in_valid(in_valid), .in_ready(in_ready1),
    .out_pixel(out_pixel1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_last(out_last1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: integer IDCT built from a cosine table derived with $cos
  function automatic void push_expected();
    longint t [64];
    longint acc, r, v, p;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 8; k++) begin
        acc = 0;
        for (int j = 0; j < 8; j++) acc += longint'(dm[j*8+i]) * longint'(cur[j*8+k]);
        r = (acc + 64) >>> 7;
        if (r > 524287) r = 524287;
        if (r < -524288) r = -524288;
        t[i*8+k] = r;
      end
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 8; k++) begin
        acc = 0;
        for (int j = 0; j < 8; j++) acc += t[i*8+j] * longint'(dm[j*8+k]);
        v = (acc + 64) >>> 7;
        p = (v < 0) ? 0 : ((v > 255) ? 255 : v);
        q0.push_back(int'(p));
        p = v + 128;
        p = (p < 0) ? 0 : ((p > 255) ? 255 : p);
        q1.push_back(int'(p));
      end
  endfunction

  task automatic set_block(input int dc, input int ac10);
    foreach (cur[i]) cur[i] = 0;
    cur[0] = dc;
    cur[8] = ac10;
  endtask

  task automatic load_block(input bit gaps);
    int  n = 0;
    int  cyc = 0;
    bit  rdy;
    while (n < 64 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_coef  = cur[n][COEF_W-1:0];
      rdy      = in_ready0;
      @(posedge clk);
      if (in_valid && rdy) n++;
    end
    if (n < 64) check("load_timeout", n, 64);
  endtask

  task automatic finish_block(input bit bp);
    int         edges = 0;
    int         got = 0;
    int         cyc = 0;
    bit         leak = 0;
    bit         stalled = 0;
    bit         v_s, l_s;
    logic [7:0] p0_s, p1_s, held0;
    int         e0, e1;
    #1;
    check("in_ready_low_after_load", in_ready0, 0);
    check("busy_after_load", busy0, 1);
    in_valid = 1'b1;
    in_coef  = 16'sd999;
    while (!out_valid0 && edges < 1100) begin
      @(posedge clk);
      edges++;
      #1;
      if (in_ready0 || in_ready1) leak = 1'b1;
    end
    check("latency", edges, 1024);
    check("no_accept_during_compute", leak, 0);
    in_valid = 1'b0;
    held0 = '0;
    while (got < 64 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check("stall_hold_pixel", out_pixel0, held0);
        check("stall_hold_valid", out_valid0, 1);
      end
      out_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
      v_s  = out_valid0;
      l_s  = out_last0;
      p0_s = out_pixel0;
      p1_s = out_pixel1;
      if (bp && v_s) check("in_ready_low_in_drain", in_ready0, 0);
      @(posedge clk);
      if (v_s && out_ready) begin
        if (q0.size() == 0 || q1.size() == 0) begin
          check("scoreboard_empty", q0.size(), 64 - got);
        end else begin
          e0 = q0.pop_front();
          e1 = q1.pop_front();
          check("pixel_offset0", p0_s, e0);
          check("pixel_offset128", p1_s, e1);
        end
        check("out_last", l_s, (got == 63));
        got++;
        stalled = 1'b0;
      end else begin
        stalled = v_s;
        held0   = p0_s;
      end
    end
    if (got < 64) check("drain_timeout", got, 64);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_drain", out_valid0, 0);
    check("in_ready_after_drain", in_ready0, 1);
  endtask

  task automatic run_block(input bit gaps, input bit bp);
    push_expected();
    load_block(gaps);
    finish_block(bp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    real s;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        s = (r == 0) ? $sqrt(1.0 / 8.0) : 0.5;
        dm[r*8+c] = int'(128.0 * s * $cos((2.0 * c + 1.0) * r * 3.14159265358979 / 16.0));
      end

    reset = 1'b1; in_valid = 1'b0; in_coef = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready0, 1);
    check("reset_out_valid", out_valid0, 0);
    check("reset_out_last", out_last0, 0);
    check("reset_busy", busy0, 0);
    check("reset_out_pixel", out_pixel0, 0);
    reset = 1'b0;

    // DC, AC, clamp-low, clamp-high blocks
    set_block(512, 0);    run_block(1'b0, 1'b0);
    set_block(0, 128);    run_block(1'b0, 1'b0);
    set_block(-512, 0);   run_block(1'b0, 1'b0);
    set_block(32767, 0);  run_block(1'b0, 1'b0);

    // Mixed random block
    foreach (cur[i]) cur[i] = $urandom_range(0, 400) - 200;
    run_block(1'b0, 1'b0);

    // Backpressure with input gaps
    set_block(512, 0);    run_block(1'b1, 1'b1);

    // Reset during PASS2 discards the block
    set_block(512, 0);
    load_block(1'b0);
    #1 in_valid = 1'b0;
    repeat (700) @(posedge clk);
    #2;
    check("busy_before_reset", busy0, 1);
    reset = 1'b1;
    #1;
    check("reset_mid_busy", busy0, 0);
    check("reset_mid_out_valid", out_valid0, 0);
    check("reset_mid_in_ready", in_ready0, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_release", in_ready0, 1);
    set_block(512, 0);    run_block(1'b0, 1'b0);

    // Back-to-back: zero block then DC block
    set_block(0, 0);      run_block(1'b0, 1'b0);
    set_block(512, 0);    run_block(1'b0, 1'b0);

    check("scoreboard_drained", q0.size() + q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
